add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, datapath width in bits per beat.
REQ-002 SHALL have parameter R, default 4, number of requesters (R >= 2); IW = clog2(R).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  R  per-requester beat valid.
REQ-006 SHALL have port req_last  input  R  beat is final word of transaction.
REQ-007 SHALL have port req_a  input  R*N  operand A words, requester i at [i*N +: N].
REQ-008 SHALL have port req_b  input  R*N  operand B words, same packing.
REQ-009 SHALL have port req_ci  input  R  carry-in, sampled on first beat only.
REQ-010 SHALL have port req_ready  output  R  beat accepted when req_valid[i] & req_ready[i].
REQ-011 SHALL have port rsp_valid  output  1  result beat valid.
REQ-012 SHALL have port rsp_ready  input  1  downstream accepts result.
REQ-013 SHALL have port rsp_c  output  N  sum word.
REQ-014 SHALL have port rsp_co  output  1  carry out of this word.
REQ-015 SHALL have port rsp_last  output  1  copy of accepted beat's req_last.
REQ-016 SHALL have port rsp_id  output  IW  index of owning requester.

Function
REQ-017 SHALL share one N-bit carry-lookahead add (a + b + carry) among R requesters, multi-word transactions sent LS word first.
REQ-018 SHALL implement states IDLE and BUSY.
REQ-019 IDLE: if any req_valid, SHALL grant lowest index >= ptr (wrapping mod R), register grant, go BUSY next cycle; no beat accepted in IDLE.
REQ-020 BUSY: req_ready[g] SHALL be (!rsp_valid | rsp_ready); all other req_ready bits 0.
REQ-021 Accepted beat: carry input SHALL be req_ci[g] on first beat, else stored carry register.
REQ-022 Accepted beat SHALL load rsp_c/rsp_co/rsp_last/rsp_id and set rsp_valid next cycle (1-cycle latency); carry register <= co.
REQ-023 rsp_valid SHALL clear when rsp_ready high and no new beat accepted that cycle; rsp fields SHALL hold stable while rsp_valid & !rsp_ready.
REQ-024 Accepting beat with req_last SHALL return to IDLE and set ptr = (g+1) mod R.
REQ-025 Grant SHALL remain locked to g until its last beat; req_valid[g] dropping mid-transaction stalls (no timeout, no regrant).
REQ-026 Single-beat transaction (req_last on first beat) SHALL be legal.
REQ-027 Word overflow SHALL wrap mod 2^N; final-beat rsp_co is transaction carry out; no other overflow flag.
REQ-028 Last-beat accept coincident with other valids SHALL arbitrate in the following IDLE cycle using updated ptr.
REQ-029 Full throughput SHALL be one beat per cycle in BUSY while rsp_ready held high.

Reset
REQ-030 rst SHALL force next cycle: state IDLE, ptr 0, carry 0, rsp_valid 0, rsp_c 0, rsp_co 0, rsp_last 0, rsp_id 0, req_ready 0.
REQ-031 rst mid-transaction SHALL discard the transaction and any pending result beat without emitting it.

Verification
REQ-032 Single beat: req0 a=FFFFFFFF b=00000001 ci=0 last=1 at cycle t -> req_ready[0] at t+1, rsp at t+2: c=00000000 co=1 last=1 id=0.
REQ-033 Two-beat 64-bit: req2 {FFFFFFFF+00000001, ci=0}, {00000000+00000000, last} -> rsp c=00000000 co=1, then c=00000001 co=0 last=1 id=2.
REQ-034 Round robin: req0..3 continuously valid single-beat -> rsp_id sequence 0,1,2,3,0,1.
REQ-035 Backpressure: rsp_ready low 5 cycles during req1 3-beat transaction -> rsp fields stable, req_ready[1]=0, all 3 beats delivered in order, carry chain correct.
REQ-036 Lock: req0 3-beat with 2-cycle valid gap while req3 valid -> req3 not granted until req0 last accepted; req3 next grant.
REQ-037 Reset mid-transaction after beat 1 of 3 -> all outputs 0 next cycle; next grant from ptr 0.

Source files
------------

// File: rtl/add_arbiter_if.sv
// Handshake bundle between R requesters and the shared adder arbiter.
// The arbiter takes the slave modport; requesters and the result sink take master.
interface add_arbiter_if #(
  parameter int unsigned N = 32,
  parameter int unsigned R = 4
);
  localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_last;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_ci;
  logic [R-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_c;
  logic           rsp_co;
  logic           rsp_last;
  logic [IW-1:0]  rsp_id;

  modport slave (
    input  req_valid, req_last, req_a, req_b, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_co, rsp_last, rsp_id
  );

  modport master (
    output req_valid, req_last, req_a, req_b, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_co, rsp_last, rsp_id
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one N-bit carry-lookahead adder among R requesters;
// a grant stays locked for a whole multi-word transaction (LS word first).
module add_arbiter #(
  parameter int unsigned N = 32,
  parameter int unsigned R = 4
) (
  input  logic          clk,
  input  logic          rst,
  add_arbiter_if.slave  bus
);
  localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, grant, pick;
  logic          pick_found;
  logic          first, carry;
  logic          sel_valid, sel_last, sel_ci;
  logic [N-1:0]  op_a, op_b, sum;
  logic          co, cin, beat_ready, accept;
  logic [R-1:0]  ready;

  logic          rsp_valid, rsp_co, rsp_last;
  logic [N-1:0]  rsp_c;
  logic [IW-1:0] rsp_id;

  // Kogge-Stone prefix adder; carry-in is folded into bit 0's generate term.
  function automatic logic [N:0] cla_add(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic         ci);
    logic [N-1:0] h, g, p, gn, pn, s;
    h    = a ^ b;
    p    = h;
    g    = a & b;
    g[0] = g[0] | (h[0] & ci);
    for (int unsigned d = 1; d < N; d = d * 2) begin
      gn = g;
      pn = p;
      for (int unsigned i = d; i < N; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    s[0] = h[0] ^ ci;
    for (int unsigned i = 1; i < N; i++) begin
      s[i] = h[i] ^ g[i-1];
    end
    return {g[N-1], s};
  endfunction

  // Lowest valid index at or above ptr, else lowest valid index overall.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < R; k++) begin
      if (!pick_found && bus.req_valid[k] && (k >= 32'(ptr))) begin
        pick       = IW'(k);
        pick_found = 1'b1;
      end
    end
    for (int unsigned k = 0; k < R; k++) begin
      if (!pick_found && bus.req_valid[k]) begin
        pick       = IW'(k);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    op_a      = '0;
    op_b      = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_ci    = 1'b0;
    for (int unsigned i = 0; i < R; i++) begin
      if (grant == IW'(i)) begin
        op_a      = bus.req_a[i*N +: N];
        op_b      = bus.req_b[i*N +: N];
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_ci    = bus.req_ci[i];
      end
    end
  end

  assign cin        = first ? sel_ci : carry;
  assign {co, sum}  = cla_add(op_a, op_b, cin);
  assign beat_ready = !rsp_valid || bus.rsp_ready;
  assign accept     = (state == BUSY) && sel_valid && beat_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found)          state_nxt = BUSY;
      BUSY:    if (accept && sel_last)  state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Output logic: only the locked requester sees ready, and only in BUSY
  always_comb begin
    ready = '0;
    if (state == BUSY) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (grant == IW'(i)) ready[i] = beat_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      grant <= '0;
      first <= 1'b0;
      carry <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) begin
        grant <= pick;
        first <= 1'b1;
      end
      if (accept) begin
        carry <= co;
        first <= 1'b0;
        if (sel_last) begin
          ptr <= (grant == IW'(R-1)) ? '0 : grant + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_co    <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_id    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_c     <= sum;
      rsp_co    <= co;
      rsp_last  <= sel_last;
      rsp_id    <= grant;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_c     = rsp_c;
  assign bus.rsp_co    = rsp_co;
  assign bus.rsp_last  = rsp_last;
  assign bus.rsp_id    = rsp_id;
endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: reset, carry chaining, round robin,
// backpressure, grant locking and mid-transaction reset.
module tb_add_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  add_arbiter_if #(.N(32), .R(4)) bus_if ();

  add_arbiter #(.N(32), .R(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [31:0] a, input logic [31:0] b, input logic ci);
    bus_if.req_valid[i]       = v;
    bus_if.req_last[i]        = l;
    bus_if.req_a[i*32 +: 32]  = a;
    bus_if.req_b[i*32 +: 32]  = b;
    bus_if.req_ci[i]          = ci;
  endtask

  task automatic clear_reqs();
    bus_if.req_valid = '0;
    bus_if.req_last  = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.req_ci    = '0;
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int got;

  initial begin
    rst = 1'b1;
    bus_if.rsp_ready = 1'b1;
    clear_reqs();
    tick();
    tick();
    chk("rst_valid", bus_if.rsp_valid, 0);
    chk("rst_c",     bus_if.rsp_c, 0);
    chk("rst_ready", bus_if.req_ready, 0);
    chk("rst_id",    bus_if.rsp_id, 0);
    rst = 1'b0;
    tick();

    // single beat with word overflow
    set_req(0, 1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    tick();
    chk("sb_ready", bus_if.req_ready, 4'b0001);
    chk("sb_nvalid", bus_if.rsp_valid, 0);
    tick();
    clear_reqs();
    chk("sb_valid", bus_if.rsp_valid, 1);
    chk("sb_c",     bus_if.rsp_c, 32'h0);
    chk("sb_co",    bus_if.rsp_co, 1);
    chk("sb_last",  bus_if.rsp_last, 1);
    chk("sb_id",    bus_if.rsp_id, 0);
    chk("sb_idle_ready", bus_if.req_ready, 0);
    tick();
    chk("sb_drain", bus_if.rsp_valid, 0);

    // two-beat 64-bit add on requester 2
    set_req(2, 1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    tick();
    chk("tb_ready", bus_if.req_ready, 4'b0100);
    tick();
    chk("tb1_c",    bus_if.rsp_c, 32'h0);
    chk("tb1_co",   bus_if.rsp_co, 1);
    chk("tb1_last", bus_if.rsp_last, 0);
    chk("tb1_id",   bus_if.rsp_id, 2);
    set_req(2, 1, 1, 32'h0, 32'h0, 0);
    tick();
    clear_reqs();
    chk("tb2_c",    bus_if.rsp_c, 32'h1);
    chk("tb2_co",   bus_if.rsp_co, 0);
    chk("tb2_last", bus_if.rsp_last, 1);
    chk("tb2_id",   bus_if.rsp_id, 2);
    tick();

    // round robin from ptr 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1, 1, 32'(i), 32'(i * 16), 0);
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      tick();
      if (bus_if.rsp_valid) begin
        chk("rr_id", bus_if.rsp_id, exp_rr[got]);
        chk("rr_c",  bus_if.rsp_c, 32'(exp_rr[got] * 17));
        got++;
      end
    end
    clear_reqs();
    chk("rr_count", got, 6);
    tick();
    tick();

    // backpressure during a 3-beat transaction on requester 1
    set_req(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    tick();
    chk("bp_grant", bus_if.req_ready, 4'b0010);
    tick();
    chk("bp1_c",  bus_if.rsp_c, 32'hFFFF_FFFF);
    chk("bp1_co", bus_if.rsp_co, 1);
    bus_if.rsp_ready = 1'b0;
    set_req(1, 1, 0, 32'h0, 32'hFFFF_FFFF, 0);
    #1;
    chk("bp_stall_ready0", bus_if.req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", bus_if.rsp_valid, 1);
      chk("bp_hold_c",     bus_if.rsp_c, 32'hFFFF_FFFF);
      chk("bp_hold_co",    bus_if.rsp_co, 1);
      chk("bp_hold_ready", bus_if.req_ready, 0);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    chk("bp2_c",    bus_if.rsp_c, 32'h0);
    chk("bp2_co",   bus_if.rsp_co, 1);
    chk("bp2_last", bus_if.rsp_last, 0);
    set_req(1, 1, 1, 32'h1234_5678, 32'h1111_1111, 0);
    tick();
    clear_reqs();
    chk("bp3_c",    bus_if.rsp_c, 32'h2345_678A);
    chk("bp3_co",   bus_if.rsp_co, 0);
    chk("bp3_last", bus_if.rsp_last, 1);
    chk("bp3_id",   bus_if.rsp_id, 1);
    tick();
    chk("bp_drain", bus_if.rsp_valid, 0);

    // grant lock: req0 stalls mid-transaction while req3 waits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1, 0, 32'h1, 32'h2, 0);
    set_req(3, 1, 1, 32'h5, 32'h6, 1);
    tick();
    chk("lk_grant", bus_if.req_ready, 4'b0001);
    tick();
    chk("lk1_c", bus_if.rsp_c, 32'h3);
    chk("lk1_id", bus_if.rsp_id, 0);
    bus_if.req_valid[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("lk_gap_ready", bus_if.req_ready, 4'b0001);
      chk("lk_gap_valid", bus_if.rsp_valid, 0);
    end
    set_req(0, 1, 0, 32'hFFFF_FFFF, 32'h1, 0);
    tick();
    chk("lk2_c",  bus_if.rsp_c, 32'h0);
    chk("lk2_co", bus_if.rsp_co, 1);
    set_req(0, 1, 1, 32'h0, 32'h0, 0);
    tick();
    set_req(0, 0, 0, 32'h0, 32'h0, 0);
    chk("lk3_c",    bus_if.rsp_c, 32'h1);
    chk("lk3_last", bus_if.rsp_last, 1);
    tick();
    chk("lk_next_grant", bus_if.req_ready, 4'b1000);
    tick();
    clear_reqs();
    chk("lk_r3_id", bus_if.rsp_id, 3);
    chk("lk_r3_c",  bus_if.rsp_c, 32'hC);
    tick();

    // reset mid-transaction, with ptr moved to 2 beforehand
    set_req(1, 1, 1, 32'h10, 32'h20, 0);
    tick();
    tick();
    clear_reqs();
    chk("mr_pre_id", bus_if.rsp_id, 1);
    tick();
    set_req(2, 1, 0, 32'h7, 32'h8, 0);
    tick();
    chk("mr_grant2", bus_if.req_ready, 4'b0100);
    tick();
    chk("mr_beat1", bus_if.rsp_c, 32'hF);
    clear_reqs();
    rst = 1'b1;
    bus_if.rsp_ready = 1'b0;
    tick();
    chk("mr_valid", bus_if.rsp_valid, 0);
    chk("mr_c",     bus_if.rsp_c, 0);
    chk("mr_co",    bus_if.rsp_co, 0);
    chk("mr_last",  bus_if.rsp_last, 0);
    chk("mr_id",    bus_if.rsp_id, 0);
    chk("mr_ready", bus_if.req_ready, 0);
    rst = 1'b0;
    bus_if.rsp_ready = 1'b1;
    set_req(1, 1, 1, 32'h3, 32'h4, 0);
    set_req(3, 1, 1, 32'h9, 32'h9, 0);
    tick();
    chk("mr_regrant", bus_if.req_ready, 4'b0010);
    chk("mr_no_stale", bus_if.rsp_valid, 0);
    tick();
    clear_reqs();
    chk("mr_new_id", bus_if.rsp_id, 1);
    chk("mr_new_c",  bus_if.rsp_c, 32'h7);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
